seg_dynamic_multi: RTL and testbench

Parametrised multi-digit 7-segment scan driver, successor to the fixed 6-digit decimal scanner. Takes pre-encoded 4-bit digit codes from an upstream converter and time-multiplexes them onto a common seg bus with one-hot digit selects. Adds:
- configurable digit count
- frame-synchronous tear-free data update with handshake
- optional leading-zero blanking and hex mode
- per-digit blink
- PWM brightness

---
 rtl/seg_dynamic_multi.sv | 204 ++++++++++++++++++++
 tb/tb_seg_dynamic_multi.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_dynamic_multi.sv
// -----------------------------------------------------------------------------
// seg_dynamic_multi
//
// Multi-digit 7-segment scan driver. Pre-encoded 4-bit digit codes are
// time-multiplexed onto a shared active-low segment bus, one digit per slot,
// with a one-hot active-high digit select. New digit data is staged in a
// pending register and copied to the live register only at a frame boundary,
// so a frame never shows a mix of old and new digits.
//
// Ports
//   sys_clk   system clock
//   sys_rst   asynchronous, active-high reset
//   data_in   digit codes, [3:0] = digit 0 (rightmost)
//   point     decimal point per digit (1 = lit)
//   blink     blink enable per digit
//   load      strobe: stage data_in/point for the next frame boundary
//   hex_mode  1 = codes A..F shown as hex letters
//   lz_blank  1 = blank leading zeros
//   bright    brightness level (all-ones = full slot)
//   seg_en    0 = display dark (counters keep running)
//   upd_done  one-cycle pulse after staged data goes live
//   seg       active-low segments, bit7 = dp, [6:0] = gfedcba
//   sel       active-high one-hot digit select
// -----------------------------------------------------------------------------
module seg_dynamic_multi #(
  parameter int          DIGITS       = 6,
  parameter logic [15:0] CNT_SEG_MAX  = 16'd49_999,
  parameter int          BRIGHT_W     = 3,
  parameter logic [7:0]  BLINK_FRAMES = 8'd80
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  lz_blank,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  seg_en,
  output logic                  upd_done,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel
);

  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  // Width of one brightness step in clocks.
  localparam logic [31:0]      STEP     = (32'(CNT_SEG_MAX) + 32'd1) >> BRIGHT_W;

  logic [15:0]          cnt_seg;
  logic [IDX_W-1:0]     idx;
  logic                 slot_end;
  logic                 frame_end;
  logic                 apply;

  logic [7:0]           frame_cnt;
  logic                 blink_phase;

  logic [4*DIGITS-1:0]  pend_data;
  logic [DIGITS-1:0]    pend_point;
  logic                 pend_valid;
  logic [4*DIGITS-1:0]  live_data;
  logic [DIGITS-1:0]    live_point;

  logic [DIGITS-1:0]    lz_vec;
  logic                 lz_above;
  logic [3:0]           cur_code;
  logic [7:0]           cur_glyph;
  logic                 cur_blank;
  logic                 lit;
  logic [31:0]          bright_thresh;
  logic [DIGITS-1:0]    sel_d;
  logic [7:0]           seg_d;

  // Glyph for a code; all-ones means the code has no glyph (blank).
  function automatic logic [7:0] decode(input logic [3:0] code, input logic hex);
    logic [7:0] s;
    case (code)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = hex ? 8'h88 : 8'hFF;
      4'hB:    s = hex ? 8'h83 : 8'hFF;
      4'hC:    s = hex ? 8'hC6 : 8'hFF;
      4'hD:    s = hex ? 8'hA1 : 8'hFF;
      4'hE:    s = hex ? 8'h86 : 8'hBF;
      default: s = hex ? 8'h8E : 8'hFF;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt_seg == CNT_SEG_MAX);
  assign frame_end = slot_end && (idx == IDX_LAST);
  // A load in the frame-end cycle bypasses the pending register.
  assign apply     = frame_end && (pend_valid || load);

  // Slot counter and digit index.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_seg <= '0;
      idx     <= '0;
    end else if (slot_end) begin
      cnt_seg <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt_seg <= cnt_seg + 16'd1;
    end
  end

  // Blink timebase: phase toggles every BLINK_FRAMES frames.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == BLINK_FRAMES - 8'd1) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt   <= frame_cnt + 8'd1;
      end
    end
  end

  // Pending/live handshake.
  // NOTE: the data registers are reset too: live must come up blank and any
  // staged data must be discarded, so they are state, not a scratch memory.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pend_data  <= '0;
      pend_point <= '0;
      pend_valid <= 1'b0;
      live_data  <= '1;
      live_point <= '0;
      upd_done   <= 1'b0;
    end else begin
      upd_done <= apply;
      if (apply) begin
        live_data  <= load ? data_in : pend_data;
        live_point <= load ? point   : pend_point;
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_data  <= data_in;
        pend_point <= point;
        pend_valid <= 1'b1;
      end
    end
  end

  // Leading-zero blanking, walked from the most significant digit down.
  // A higher digit counts as blank if it is 4'hF in decimal mode or was
  // itself lz-blanked; digit 0 is never blanked.
  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    lz_vec   = '0;
    lz_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz_vec[i] = lz_blank && lz_above && !live_point[i] &&
                  (live_data[4*i +: 4] == 4'h0);
      lz_above  = lz_above &&
                  (lz_vec[i] || (!hex_mode && live_data[4*i +: 4] == 4'hF));
    end
  end

  assign bright_thresh = STEP * (32'(bright) + 32'd1);

  // Next-cycle outputs for the current slot.
  always_comb begin
    cur_code  = live_data[4*int'(idx) +: 4];
    cur_glyph = decode(cur_code, hex_mode);
    cur_blank = (cur_glyph == 8'hFF) || lz_vec[idx] || (blink[idx] && blink_phase);
    lit       = seg_en && ((&bright) || (32'(cnt_seg) < bright_thresh));
    sel_d     = '0;
    seg_d     = 8'hFF;
    if (lit) begin
      sel_d[idx] = 1'b1;
      if (!cur_blank) begin
        seg_d = {~live_point[idx], cur_glyph[6:0]};
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel <= '0;
      seg <= 8'hFF;
    end else begin
      sel <= sel_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_dynamic_multi.sv
// -----------------------------------------------------------------------------
// tb_seg_dynamic_multi
//
// Directed bench for seg_dynamic_multi with DIGITS=4, CNT_SEG_MAX=15,
// BRIGHT_W=2, BLINK_FRAMES=2. A frame is 64 cycles; outputs for internal
// cycle k appear after posedge k+1, so output frame f occupies the sample
// points with cyc = 64f+1 .. 64f+64 (cyc counts posedges since reset).
// -----------------------------------------------------------------------------
module tb_seg_dynamic_multi;

  logic        sys_clk;
  logic        sys_rst;
  logic [15:0] data_in;
  logic [3:0]  point;
  logic [3:0]  blink;
  logic        load;
  logic        hex_mode;
  logic        lz_blank;
  logic [1:0]  bright;
  logic        seg_en;
  logic        upd_done;
  logic [7:0]  seg;
  logic [3:0]  sel;

  int checks   = 0;
  int failures = 0;

  int cyc;
  int upd_cnt = 0;

  logic [7:0]  cap_seg  [4];
  logic [15:0] cap_mask [4];
  bit          cap_seen [4];
  int          cap_bad;
  int          cap_frame;

  seg_dynamic_multi #(
    .DIGITS       (4),
    .CNT_SEG_MAX  (16'd15),
    .BRIGHT_W     (2),
    .BLINK_FRAMES (8'd2)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .data_in  (data_in),
    .point    (point),
    .blink    (blink),
    .load     (load),
    .hex_mode (hex_mode),
    .lz_blank (lz_blank),
    .bright   (bright),
    .seg_en   (seg_en),
    .upd_done (upd_done),
    .seg      (seg),
    .sel      (sel)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(negedge sys_clk) begin
    if (upd_done === 1'b1) upd_cnt <= upd_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the first negedge (possibly this one)
  // where output frame sampling begins.
  task automatic wait_frame_start();
    int guard;
    guard = 0;
    while ((cyc % 64) != 1 && guard < 200) begin
      @(negedge sys_clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL frame_align: cyc=%0d never reached frame start", cyc);
    end
  endtask

  // Samples one whole output frame: per digit the seg value while selected
  // and a mask of the slot positions where it was selected.
  task automatic capture_frame();
    int d;
    for (int i = 0; i < 4; i++) begin
      cap_seg[i]  = 8'hFF;
      cap_mask[i] = '0;
      cap_seen[i] = 1'b0;
    end
    cap_bad = 0;
    wait_frame_start();
    cap_frame = (cyc - 1) / 64;
    for (int j = 0; j < 64; j++) begin
      if (j > 0) @(negedge sys_clk);
      d = j / 16;
      if (sel === 4'b0000) begin
        if (seg !== 8'hFF) cap_bad++;
      end else if (sel === (4'b0001 << d)) begin
        if (cap_seen[d] && seg !== cap_seg[d]) cap_bad++;
        cap_seg[d]          = seg;
        cap_seen[d]         = 1'b1;
        cap_mask[d][j % 16] = 1'b1;
      end else begin
        cap_bad++;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    @(negedge sys_clk);
    data_in = d;
    point   = p;
    load    = 1'b1;
    @(negedge sys_clk);
    load    = 1'b0;
  endtask

  // Loads early in a frame so the data is live from the following frame.
  task automatic apply_data(input logic [15:0] d, input logic [3:0] p);
    wait_frame_start();
    do_load(d, p);
  endtask

  task automatic test_reset_and_first_load();
    logic [31:0] exp;
    int          base;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (sel !== 4'b0000) begin failures++; $display("FAIL reset_sel: got %b want 0000", sel); end
    checks++;
    if (seg !== 8'hFF) begin failures++; $display("FAIL reset_seg: got %h want ff", seg); end
    checks++;
    if (upd_done !== 1'b0) begin failures++; $display("FAIL reset_upd: got %b want 0", upd_done); end
    base    = upd_cnt;
    data_in = 16'h1234;
    point   = 4'b0100;
    load    = 1'b1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    load    = 1'b0;
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cap_seg[d] !== 8'hFF) begin
        failures++;
        $display("FAIL first_frame_blank d%0d: got %h want ff", d, cap_seg[d]);
      end
    end
    capture_frame();
    exp = 32'hF924B099;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cap_seg[d] !== exp[8*d +: 8]) begin
        failures++;
        $display("FAIL live_1234 d%0d: got %h want %h", d, cap_seg[d], exp[8*d +: 8]);
      end
      checks++;
      if (cap_mask[d] !== 16'hFFFF) begin
        failures++;
        $display("FAIL full_slot d%0d: got %h want ffff", d, cap_mask[d]);
      end
    end
    checks++;
    if (cap_bad !== 0) begin failures++; $display("FAIL scan_order: got %0d bad samples want 0", cap_bad); end
    #1;
    checks++;
    if (upd_cnt - base !== 1) begin
      failures++;
      $display("FAIL first_upd_done: got %0d pulses want 1", upd_cnt - base);
    end
  endtask

  task automatic test_lz_blank();
    logic [31:0] exp [3];
    exp[0] = 32'hFFFF92C0;
    exp[1] = 32'hC0C092C0;
    exp[2] = 32'hFF4092C0;
    for (int t = 0; t < 3; t++) begin
      if (t == 0) begin lz_blank = 1'b1; apply_data(16'h0050, 4'b0000); end
      if (t == 1) lz_blank = 1'b0;
      if (t == 2) begin lz_blank = 1'b1; apply_data(16'h0050, 4'b0100); end
      capture_frame();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (cap_seg[d] !== exp[t][8*d +: 8]) begin
          failures++;
          $display("FAIL lz_case%0d d%0d: got %h want %h", t, d, cap_seg[d], exp[t][8*d +: 8]);
        end
      end
      checks++;
      if (cap_mask[3] !== 16'hFFFF) begin
        failures++;
        $display("FAIL lz_sel_driven case%0d: got %h want ffff", t, cap_mask[3]);
      end
    end
  endtask

  task automatic test_brightness();
    logic [15:0] exp_mask [3];
    exp_mask[0] = 16'h000F;
    exp_mask[1] = 16'h00FF;
    exp_mask[2] = 16'h0000;
    for (int t = 0; t < 3; t++) begin
      if (t == 0) bright = 2'd0;
      if (t == 1) bright = 2'd1;
      if (t == 2) begin bright = 2'd3; seg_en = 1'b0; end
      capture_frame();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (cap_mask[d] !== exp_mask[t]) begin
          failures++;
          $display("FAIL bright_case%0d d%0d: got %h want %h", t, d, cap_mask[d], exp_mask[t]);
        end
      end
      checks++;
      if (cap_bad !== 0) begin
        failures++;
        $display("FAIL bright_dark_seg case%0d: got %0d bad samples want 0", t, cap_bad);
      end
    end
    seg_en = 1'b1;
    checks++;
    capture_frame();
    if (cap_seg[2] !== 8'h40) begin
      failures++;
      $display("FAIL seg_en_restore: got %h want 40", cap_seg[2]);
    end
  endtask

  task automatic test_hex_mode();
    logic [31:0] exp [2];
    exp[0] = 32'h8883868E;
    exp[1] = 32'hFFFFBFFF;
    lz_blank = 1'b0;
    hex_mode = 1'b1;
    apply_data(16'hABEF, 4'b0000);
    for (int t = 0; t < 2; t++) begin
      if (t == 1) hex_mode = 1'b0;
      capture_frame();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (cap_seg[d] !== exp[t][8*d +: 8]) begin
          failures++;
          $display("FAIL hex_case%0d d%0d: got %h want %h", t, d, cap_seg[d], exp[t][8*d +: 8]);
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp0;
    apply_data(16'h1234, 4'b0000);
    blink = 4'b0001;
    for (int t = 0; t < 4; t++) begin
      capture_frame();
      // Phase is 1 during output frames 2,3, 6,7, ... counted from reset.
      exp0 = (((cap_frame / 2) % 2) == 1) ? 8'hFF : 8'h99;
      checks++;
      if (cap_seg[0] !== exp0) begin
        failures++;
        $display("FAIL blink_d0 frame%0d: got %h want %h", cap_frame, cap_seg[0], exp0);
      end
      checks++;
      if (cap_seg[3] !== 8'hF9) begin
        failures++;
        $display("FAIL blink_d3 frame%0d: got %h want f9", cap_frame, cap_seg[3]);
      end
    end
    blink = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int          base;
    int          guard;
    // Three loads in one frame: only the last goes live, one pulse.
    #1;
    base = upd_cnt;
    wait_frame_start();
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    do_load(16'h3333, 4'b0000);
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cap_seg[d] !== 8'hB0) begin
        failures++;
        $display("FAIL latest_wins d%0d: got %h want b0", d, cap_seg[d]);
      end
    end
    #1;
    checks++;
    if (upd_cnt - base !== 1) begin
      failures++;
      $display("FAIL multi_load_upd: got %0d pulses want 1", upd_cnt - base);
    end
    // Load exactly in the frame-end cycle goes live immediately.
    base  = upd_cnt;
    guard = 0;
    while ((cyc % 64) != 63 && guard < 200) begin
      @(negedge sys_clk);
      guard++;
    end
    checks++;
    if (guard >= 200) begin failures++; $display("FAIL frame_end_align: cyc=%0d", cyc); end
    data_in = 16'h5678;
    point   = 4'b0000;
    load    = 1'b1;
    @(negedge sys_clk);
    load    = 1'b0;
    capture_frame();
    exp = 32'h9282F880;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cap_seg[d] !== exp[8*d +: 8]) begin
        failures++;
        $display("FAIL bypass_load d%0d: got %h want %h", d, cap_seg[d], exp[8*d +: 8]);
      end
    end
    capture_frame();
    #1;
    checks++;
    if (upd_cnt - base !== 1) begin
      failures++;
      $display("FAIL bypass_upd: got %0d pulses want 1", upd_cnt - base);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    wait_frame_start();
    repeat (20) @(negedge sys_clk);
    do_load(16'h9999, 4'b1111);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    checks++;
    if (sel !== 4'b0000) begin failures++; $display("FAIL midreset_sel: got %b want 0000", sel); end
    checks++;
    if (seg !== 8'hFF) begin failures++; $display("FAIL midreset_seg: got %h want ff", seg); end
    checks++;
    if (upd_done !== 1'b0) begin failures++; $display("FAIL midreset_upd: got %b want 0", upd_done); end
    base = upd_cnt;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      capture_frame();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (cap_seg[d] !== 8'hFF) begin
          failures++;
          $display("FAIL post_reset_blank f%0d d%0d: got %h want ff", f, d, cap_seg[d]);
        end
      end
    end
    #1;
    checks++;
    if (upd_cnt - base !== 0) begin
      failures++;
      $display("FAIL pending_discarded: got %0d pulses want 0", upd_cnt - base);
    end
  endtask

  initial begin
    sys_rst  = 1'b1;
    data_in  = '0;
    point    = '0;
    blink    = '0;
    load     = 1'b0;
    hex_mode = 1'b0;
    lz_blank = 1'b0;
    bright   = 2'd3;
    seg_en   = 1'b1;
    test_reset_and_first_load();
    test_lz_blank();
    test_brightness();
    test_hex_mode();
    test_blink();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
